// File: rtl/program_load_controller.sv
// -----------------------------------------------------------------------------
// program_load_controller
//
// Sits between the UART receiver and the instruction fetch stage. It loads a
// program from the host byte stream into instruction memory one word at a
// time. It then controls the fetch stage stall so the program runs
// continuously, runs a single step, or stays halted.
//
// Host protocol (one byte per i_rx_valid strobe):
//   'L' N b0 b1 ...  load N words; each word is sent MSB byte first
//   'R'              run until byte 'H' arrives or fetch outputs HALT_WORD
//   'S'              release the stall for exactly one cycle
//   'H'              no-op while idle; stops a run
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   i_rx_valid      one-cycle strobe, i_rx_data is valid
//   i_rx_data       received byte
//   i_instruction   word currently presented by the fetch stage
//   o_imem_we       imem write enable (one-cycle pulse)
//   o_imem_addr     imem write word address
//   o_imem_data     imem write data
//   o_stall         fetch stall (1 = hold PC)
//   o_pipe_rst      one-cycle restart pulse to fetch, issued with the last write
//   o_done          one-cycle pulse: HALT_WORD was fetched while running
//   o_err           one-cycle pulse: unknown command or illegal word count
//   o_state         current state encoding (debug)
// -----------------------------------------------------------------------------
module program_load_controller #(
    parameter  int unsigned     SIZE            = 32,
    parameter  int unsigned     MAX_INSTRUCTION = 13,
    parameter  logic [SIZE-1:0] HALT_WORD       = {SIZE{1'b1}},
    localparam int unsigned     ADDR_W          = (MAX_INSTRUCTION > 1) ? $clog2(MAX_INSTRUCTION) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    input  logic [SIZE-1:0]   i_instruction,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [SIZE-1:0]   o_imem_data,
    output logic              o_stall,
    output logic              o_pipe_rst,
    output logic              o_done,
    output logic              o_err,
    output logic [2:0]        o_state
);

    localparam int unsigned BYTES  = SIZE / 8;
    localparam int unsigned BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [BCNT_W-1:0] BYTE_LAST = BCNT_W'(BYTES - 1);
    localparam logic [7:0]        MAX_N     = 8'(MAX_INSTRUCTION);

    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_CNT  = 3'd1,
        ST_LOAD_DATA = 3'd2,
        ST_RUN       = 3'd3,
        ST_STEP      = 3'd4
    } state_e;

    state_e            state_q;
    logic [BCNT_W-1:0] byte_cnt_q;   // bytes of the current word received so far
    logic [ADDR_W-1:0] word_idx_q;   // address of the word being assembled
    logic [ADDR_W-1:0] word_last_q;  // N-1, the address of the final word
    logic [SIZE-1:0]   shift_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [SIZE-1:0]   imem_data_q;
    logic              stall_q;
    logic              pipe_rst_q;
    logic              done_q;
    logic              err_q;

    // The word as it stands once the incoming byte is shifted in (MSB first).
    logic [SIZE-1:0] shift_d;
    assign shift_d = (shift_q << 8) | SIZE'(i_rx_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            word_idx_q  <= '0;
            word_last_q <= '0;
            shift_q     <= '0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            stall_q     <= 1'b1;
            pipe_rst_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults first; a later assignment in this
            // block wins, so every pulse drops back to 0 unless raised below.
            imem_we_q  <= 1'b0;
            pipe_rst_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    stall_q <= 1'b1;
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: state_q <= ST_LOAD_CNT;
                            CMD_RUN: begin
                                state_q <= ST_RUN;
                                stall_q <= 1'b0;
                            end
                            CMD_STEP: begin
                                state_q <= ST_STEP;
                                stall_q <= 1'b0;
                            end
                            CMD_HALT: state_q <= ST_IDLE;
                            default:  err_q   <= 1'b1;
                        endcase
                    end
                end

                ST_LOAD_CNT: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == 8'd0 || i_rx_data > MAX_N) begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            word_last_q <= ADDR_W'(i_rx_data - 8'd1);
                            word_idx_q  <= '0;
                            byte_cnt_q  <= '0;
                            state_q     <= ST_LOAD_DATA;
                        end
                    end
                end

                ST_LOAD_DATA: begin
                    if (i_rx_valid) begin
                        shift_q <= shift_d;
                        if (byte_cnt_q == BYTE_LAST) begin
                            byte_cnt_q  <= '0;
                            imem_we_q   <= 1'b1;
                            imem_addr_q <= word_idx_q;
                            imem_data_q <= shift_d;
                            // The last word restarts fetch so the new program runs from PC 0.
                            // The index is held here so it never passes N-1.
                            if (word_idx_q == word_last_q) begin
                                pipe_rst_q <= 1'b1;
                                state_q    <= ST_IDLE;
                            end else begin
                                word_idx_q <= word_idx_q + 1'b1;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    // A fetched halt word takes priority so that o_done still
                    // pulses when an 'H' byte arrives in the same cycle.
                    if (i_instruction == HALT_WORD) begin
                        done_q  <= 1'b1;
                        stall_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (i_rx_valid && i_rx_data == CMD_HALT) begin
                        stall_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end

                ST_STEP: begin
                    stall_q <= 1'b1;
                    state_q <= ST_IDLE;
                end

                default: begin
                    stall_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_imem_we   = imem_we_q;
    assign o_imem_addr = imem_addr_q;
    assign o_imem_data = imem_data_q;
    assign o_stall     = stall_q;
    assign o_pipe_rst  = pipe_rst_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_state     = state_q;

endmodule
